ps_setpoint_receiver: RTL and testbench

Receiving end of the power-supply setpoint stream produced by the AWG and forwarded by psMux. It accepts one packet of SETPOINT_COUNT words per sample interval (TDATA/TVALID/TLAST, no TREADY), validates packet length, and double-buffers complete packets so firmware always reads a coherent setpoint set. It also counts good and bad packets and flags a stale stream when no good packet arrives within a timeout.

---
 rtl/ps_setpoint_receiver_if.sv | 15 +
 rtl/ps_setpoint_receiver.sv | 184 ++++++++++++++++++
 tb/tb_ps_setpoint_receiver.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps_setpoint_receiver_if.sv
// ps_setpoint_receiver_if: setpoint word stream (no back-pressure).
//   axisTDATA  - setpoint word
//   axisTVALID - word valid; every valid beat is taken
//   axisTLAST  - last word of a packet, qualified by axisTVALID
// master drives the stream, slave (the receiver) samples it.
interface ps_setpoint_receiver_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] axisTDATA;
  logic                  axisTVALID;
  logic                  axisTLAST;

  modport master (output axisTDATA, output axisTVALID, output axisTLAST);
  modport slave  (input  axisTDATA, input  axisTVALID, input  axisTLAST);
endinterface

// File: rtl/ps_setpoint_receiver.sv
// ps_setpoint_receiver: receives fixed-length setpoint packets, checks their
// length, and double-buffers complete packets so firmware always reads a
// coherent setpoint set. Counts good/bad packets and flags a stale stream.
// Ports:
//   sysClk, sysReset_n - clock, asynchronous active-low reset
//   axis               - setpoint stream (slave side)
//   csrStrobe          - GPIO_OUT[0]=1 clears packet and error counters
//   addrStrobe         - loads the read index from GPIO_OUT
//   GPIO_OUT           - firmware write data
//   readData           - registered word of the active bank at the read index
//   status             - {stale, discarding, 6'b0, errorCount, packetCount}
//   packetStrobe       - one-cycle pulse per committed packet
module ps_setpoint_receiver #(
  parameter int unsigned SETPOINT_COUNT = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 125000
) (
  input  logic                    sysClk,
  input  logic                    sysReset_n,
  ps_setpoint_receiver_if.slave   axis,
  input  logic                    csrStrobe,
  input  logic                    addrStrobe,
  input  logic [31:0]             GPIO_OUT,
  output logic [DATA_WIDTH-1:0]   readData,
  output logic [31:0]             status,
  output logic                    packetStrobe
);

  localparam int unsigned IW = $clog2(SETPOINT_COUNT);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] LAST_IDX = CW'(SETPOINT_COUNT - 1);
  localparam logic [CW-1:0] SP_COUNT = CW'(SETPOINT_COUNT);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_DISCARD
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_word_count;
  logic                  r_active;
  logic                  r_have_data;
  logic [IW-1:0]         r_read_index;
  logic [15:0]           r_packet_count;
  logic [7:0]            r_error_count;
  logic [TW-1:0]         r_timeout;
  logic                  r_stale;
  logic                  r_discarding;
  logic                  r_packet_strobe;
  logic [DATA_WIDTH-1:0] r_read_data;

  logic [DATA_WIDTH-1:0] r_bank0 [SETPOINT_COUNT];
  logic [DATA_WIDTH-1:0] r_bank1 [SETPOINT_COUNT];

  state_t                w_state_nxt;
  logic [CW-1:0]         w_word_count_nxt;
  logic                  w_wr_en;
  logic [IW-1:0]         w_wr_index;
  logic                  w_commit;
  logic                  w_error;
  logic                  w_clear;
  logic [TW-1:0]         w_timeout_nxt;
  logic                  w_index_ok;
  logic [DATA_WIDTH-1:0] w_bank_word;
  logic                  w_unused_gpio;

  assign w_clear       = csrStrobe & GPIO_OUT[0];
  assign w_unused_gpio = ^GPIO_OUT[31:IW];

  // Packet framing: length check and shadow-bank write control.
  always_comb begin
    w_state_nxt      = r_state;
    w_word_count_nxt = r_word_count;
    w_wr_en          = 1'b0;
    w_wr_index       = r_word_count[IW-1:0];
    w_commit         = 1'b0;
    w_error          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (axis.axisTVALID) begin
          w_wr_en          = 1'b1;
          w_wr_index       = '0;
          w_word_count_nxt = CW'(1);
          // A one-word packet is always short (SETPOINT_COUNT >= 2).
          if (axis.axisTLAST) w_error     = 1'b1;
          else                w_state_nxt = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        if (axis.axisTVALID) begin
          w_wr_en          = 1'b1;
          w_word_count_nxt = r_word_count + CW'(1);
          if (r_word_count == LAST_IDX) begin
            if (axis.axisTLAST) begin
              w_commit    = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_error     = 1'b1;
              w_state_nxt = ST_DISCARD;
            end
          end else if (axis.axisTLAST) begin
            w_error     = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (axis.axisTVALID && axis.axisTLAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      r_state      <= ST_IDLE;
      r_word_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_word_count <= w_word_count_nxt;
    end
  end

  // Shadow bank is the one not selected by r_active; RAM is not reset.
  always_ff @(posedge sysClk) begin
    if (w_wr_en) begin
      if (r_active) r_bank0[w_wr_index] <= axis.axisTDATA;
      else          r_bank1[w_wr_index] <= axis.axisTDATA;
    end
  end

  // Cycles since the last commit, saturating at the stale threshold.
  assign w_timeout_nxt = w_commit             ? '0 :
                         (r_timeout == TO_MAX) ? r_timeout :
                                                 r_timeout + TW'(1);

  assign w_index_ok  = ({1'b0, r_read_index} < SP_COUNT);
  assign w_bank_word = r_active ? r_bank1[r_read_index] : r_bank0[r_read_index];

  // Bank swap, counters, stale flag and registered read port.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      r_active        <= 1'b0;
      r_have_data     <= 1'b0;
      r_read_index    <= '0;
      r_packet_count  <= '0;
      r_error_count   <= '0;
      r_timeout       <= TO_MAX;
      r_stale         <= 1'b1;
      r_discarding    <= 1'b0;
      r_packet_strobe <= 1'b0;
      r_read_data     <= '0;
    end else begin
      if (w_commit) begin
        r_active    <= ~r_active;
        r_have_data <= 1'b1;
      end
      if (addrStrobe) r_read_index <= GPIO_OUT[IW-1:0];

      // A firmware clear overrides a same-cycle increment.
      if (w_clear)       r_packet_count <= '0;
      else if (w_commit) r_packet_count <= r_packet_count + 16'd1;

      if (w_clear)                                r_error_count <= '0;
      else if (w_error && (r_error_count != 8'hFF)) r_error_count <= r_error_count + 8'd1;

      r_timeout       <= w_timeout_nxt;
      r_stale         <= (w_timeout_nxt == TO_MAX);
      r_discarding    <= (w_state_nxt == ST_DISCARD);
      r_packet_strobe <= w_commit;
      r_read_data     <= (r_have_data && w_index_ok) ? w_bank_word : '0;
    end
  end

  assign readData     = r_read_data;
  assign status       = {r_stale, r_discarding, 6'b0, r_error_count, r_packet_count};
  assign packetStrobe = r_packet_strobe;

endmodule

// File: tb/tb_ps_setpoint_receiver.sv
module tb_ps_setpoint_receiver;

  localparam int SC = 32;
  localparam int TO = 100;
  localparam int IW = $clog2(SC);

  logic        sysClk = 1'b0;
  logic        sysReset_n;
  logic        csrStrobe;
  logic        addrStrobe;
  logic [31:0] GPIO_OUT;
  logic [31:0] readData;
  logic [31:0] status;
  logic        packetStrobe;

  ps_setpoint_receiver_if #(.DATA_WIDTH(32)) axis_if ();

  ps_setpoint_receiver #(
    .SETPOINT_COUNT(SC),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sysClk      (sysClk),
    .sysReset_n  (sysReset_n),
    .axis        (axis_if),
    .csrStrobe   (csrStrobe),
    .addrStrobe  (addrStrobe),
    .GPIO_OUT    (GPIO_OUT),
    .readData    (readData),
    .status      (status),
    .packetStrobe(packetStrobe)
  );

  always #5 sysClk = ~sysClk;

  int checks   = 0;
  int failures = 0;

  // Reference model: last complete packet, packet in flight, counters.
  logic [31:0] m_words [SC];
  logic [31:0] m_pkt [$];
  bit          m_have, m_discard, m_strobe;
  int          m_idx, m_pcnt, m_ecnt, m_since;
  logic [31:0] m_rd;

  logic [31:0] sent_q [$];
  int          strobe_seen;
  bit          rnd_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {(m_since == TO), m_discard, 6'b0, 8'(m_ecnt), 16'(m_pcnt)};
  endfunction

  task automatic model_reset();
    m_pkt.delete();
    m_have    = 0;
    m_discard = 0;
    m_strobe  = 0;
    m_idx     = 0;
    m_pcnt    = 0;
    m_ecnt    = 0;
    m_since   = TO;
    m_rd      = '0;
  endtask

  // One clock: drive at negedge, update the model for the edge, check after it.
  task automatic step(input logic v, input logic [31:0] d, input logic l,
                      input logic csr, input logic addr, input logic [31:0] g);
    bit commit, err;
    @(negedge sysClk);
    axis_if.axisTVALID = v;
    axis_if.axisTDATA  = d;
    axis_if.axisTLAST  = l;
    csrStrobe          = csr;
    addrStrobe         = addr;
    GPIO_OUT           = g;
    @(posedge sysClk);
    m_rd   = (m_have && m_idx < SC) ? m_words[m_idx] : 32'h0;
    commit = 0;
    err    = 0;
    if (v) begin
      if (m_discard) begin
        if (l) m_discard = 0;
      end else begin
        m_pkt.push_back(d);
        if (l) begin
          if (m_pkt.size() == SC) commit = 1;
          else                    err    = 1;
          if (commit) for (int i = 0; i < SC; i++) m_words[i] = m_pkt[i];
          m_pkt.delete();
        end else if (m_pkt.size() == SC) begin
          err       = 1;
          m_discard = 1;
          m_pkt.delete();
        end
      end
    end
    m_strobe = commit;
    if (commit) begin
      m_pcnt  = (m_pcnt + 1) % 65536;
      m_have  = 1;
      m_since = 0;
    end else if (m_since < TO) begin
      m_since++;
    end
    if (err && m_ecnt < 255) m_ecnt++;
    if (csr && g[0]) begin
      m_pcnt = 0;
      m_ecnt = 0;
    end
    if (addr) m_idx = int'(g[IW-1:0]);
    #1;
    if (packetStrobe === 1'b1) strobe_seen++;
    chk("readData", readData, m_rd);
    chk("status", status, exp_status());
    chk("packetStrobe", {31'b0, packetStrobe}, {31'b0, m_strobe});
  endtask

  task automatic idle();
    logic a;
    a = rnd_addr && ($urandom_range(3) == 0);
    step(1'b0, $urandom, 1'($urandom_range(1)), 1'b0, a, $urandom);
  endtask

  task automatic set_index(input int idx);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'(idx));
  endtask

  task automatic clear_counts();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1);
  endtask

  task automatic send_pkt(input int len, input bit with_last, input logic [31:0] base,
                          input bit rnd, input int gap_pct, input bit clr_last);
    logic [31:0] w;
    logic        last;
    sent_q.delete();
    for (int i = 0; i < len; i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) idle();
      w    = rnd ? $urandom : base + 32'(i);
      last = with_last && (i == len - 1);
      sent_q.push_back(w);
      step(1'b1, w, last, clr_last && last, 1'b0, (clr_last && last) ? 32'h1 : $urandom);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge sysClk);
    sysReset_n         = 1'b0;
    axis_if.axisTVALID = 1'b0;
    axis_if.axisTLAST  = 1'b0;
    axis_if.axisTDATA  = '0;
    csrStrobe          = 1'b0;
    addrStrobe         = 1'b0;
    GPIO_OUT           = '0;
    model_reset();
    #1;
    chk("rst_readData", readData, 32'h0);
    chk("rst_status", status, 32'h8000_0000);
    chk("rst_strobe", {31'b0, packetStrobe}, 32'h0);
    repeat (cycles) begin
      @(posedge sysClk);
      #1;
      chk("rst_hold_readData", readData, 32'h0);
      chk("rst_hold_status", status, 32'h8000_0000);
    end
    @(negedge sysClk);
    sysReset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] tmp;
    int          kind, len;
    sysReset_n         = 1'b0;
    axis_if.axisTVALID = 1'b0;
    axis_if.axisTLAST  = 1'b0;
    axis_if.axisTDATA  = '0;
    csrStrobe          = 1'b0;
    addrStrobe         = 1'b0;
    GPIO_OUT           = '0;
    rnd_addr           = 0;
    strobe_seen        = 0;
    model_reset();
    do_reset(3);

    // Good packet 0x100..0x11F, then read index 5.
    send_pkt(SC, 1, 32'h100, 0, 0, 0);
    idle();
    chk("t1_pkt_count", {16'h0, status[15:0]}, 32'h1);
    chk("t1_stale", {31'b0, status[31]}, 32'h0);
    set_index(5);
    idle();
    chk("t1_read5", readData, 32'h105);
    chk("t1_strobes", 32'(strobe_seen), 32'h1);

    // Short packet, then good packet 0x200..0x21F.
    clear_counts();
    strobe_seen = 0;
    send_pkt(11, 1, 32'h900, 0, 0, 0);
    idle();
    chk("t2_err_count", {24'h0, status[23:16]}, 32'h1);
    chk("t2_no_strobe", 32'(strobe_seen), 32'h0);
    send_pkt(SC, 1, 32'h200, 0, 30, 0);
    idle();
    chk("t2_pkt_count", {16'h0, status[15:0]}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      tmp = 32'h200 + 32'(k * 10 + 1);
      set_index(k * 10 + 1);
      idle();
      chk("t2_read", readData, tmp);
    end
    set_index(31);

    // Long packet of 40 words: error at beat 31, discard until TLAST.
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'h500 + 32'(i), i == 39, 1'b0, 1'b0, 32'h0);
      if (i == 31) begin
        chk("t3_err_at_31", {24'h0, status[23:16]}, 32'h1);
        chk("t3_discarding", {31'b0, status[30]}, 32'h1);
      end
    end
    chk("t3_discard_done", {31'b0, status[30]}, 32'h0);
    idle();
    chk("t3_bank_kept", readData, 32'h21F);

    // Back-to-back packets while firmware holds index 31.
    clear_counts();
    send_pkt(SC, 1, 32'h300, 0, 0, 0);
    send_pkt(SC, 1, 32'h400, 0, 0, 0);
    idle();
    chk("t4_read31", readData, 32'h41F);
    chk("t4_pkt_count", {16'h0, status[15:0]}, 32'h2);

    // Stale timeout after a commit, then clear coinciding with a commit.
    send_pkt(SC, 1, 32'h0, 1, 0, 0);
    for (int k = 1; k <= TO + 10; k++) begin
      idle();
      if (k == TO - 1) chk("t5_not_stale", {31'b0, status[31]}, 32'h0);
      if (k == TO)     chk("t5_stale", {31'b0, status[31]}, 32'h1);
    end
    send_pkt(SC, 1, 32'h0, 1, 0, 1);
    chk("t5_clear_wins", {16'h0, status[15:0]}, 32'h0);
    chk("t5_stale_clr", {31'b0, status[31]}, 32'h0);

    // Error counter saturation with one-word packets.
    clear_counts();
    repeat (260) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("sat_err_count", {24'h0, status[23:16]}, 32'hFF);

    // Reset in the middle of a packet, then a full good packet.
    send_pkt(15, 0, 32'h700, 0, 0, 0);
    do_reset(2);
    strobe_seen = 0;
    send_pkt(SC, 1, 32'h0, 1, 20, 0);
    idle();
    chk("t6_strobes", 32'(strobe_seen), 32'h1);
    chk("t6_pkt_count", {16'h0, status[15:0]}, 32'h1);
    for (int k = 0; k < SC; k++) begin
      tmp = sent_q[k];
      set_index(k);
      idle();
      chk("t6_word", readData, tmp);
    end

    // Randomized mix of good, short and long packets with gaps.
    rnd_addr = 1;
    repeat (60) begin
      kind = $urandom_range(9);
      if (kind < 6)      len = SC;
      else if (kind < 8) len = $urandom_range(1, SC - 1);
      else               len = $urandom_range(SC + 1, SC + 8);
      send_pkt(len, 1, 32'h0, 1, 20, $urandom_range(9) == 0);
      if ($urandom_range(9) == 0) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, $urandom);
      idle();
    end
    repeat (5) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
